stack_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for stack-based control transfers (CALL, RET, RTI, interrupt entry) at the decode stage.

---
 rtl/stack_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_stack_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq_ctrl.sv
// Stack sequencer for CALL/RET/RTI/interrupt entry: owns SP, drives a req/ack stack port, stalls decode.
// Optional STACK_BOUNDS_CHECK_EN turns SP over/underflow into a stack_err abort. Assumes PC_W == 2*W.
module stack_seq_ctrl #(
    parameter int              W           = 16,
    parameter int              PC_W        = 32,
    parameter logic [W-1:0]    STACK_START = W'(2**11 - 1),
    parameter logic [PC_W-1:0] INT_VECTOR  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [1:0]      op_kind,
    input  logic [W-1:0]    target,
    input  logic            interrupt,
    input  logic [PC_W-1:0] pc_cur,
    input  logic [3:0]      flags_in,
    input  logic [W-1:0]    mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [W-1:0]    mem_addr,
    output logic [W-1:0]    mem_wdata,
    output logic [W-1:0]    sp,
    output logic            pc_enable,
    output logic            fd_enable,
    output logic            flush,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            flags_load,
    output logic [3:0]      flags_out,
    output logic            int_ack,
    output logic            stack_err
);

    typedef enum logic [2:0] {
        IDLE, PUSH_HI, PUSH_LO, PUSH_FL, POP_FL, POP_LO, POP_HI, JUMP
    } state_t;

    localparam logic [PC_W-1:0] LO_MASK = PC_W'({W{1'b1}});

    state_t          state_q, state_d;
    logic [W-1:0]    sp_q, sp_d;
    logic            int_pending_q, int_pending_d;
    logic            is_int_q, is_int_d;
    logic            is_rti_q, is_rti_d;
    logic [PC_W-1:0] ret_pc_q, ret_pc_d;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    logic [3:0]      flags_sv_q, flags_sv_d;
    logic [3:0]      flags_rs_q, flags_rs_d;
    logic            start;
    logic            push_blocked, pop_blocked;

    always_comb begin
`ifdef STACK_BOUNDS_CHECK_EN
        push_blocked = (sp_q == '0);
        pop_blocked  = (sp_q == STACK_START);
`else
        push_blocked = 1'b0;
        pop_blocked  = 1'b0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        int_pending_d = int_pending_q | interrupt;
        is_int_d      = is_int_q;
        is_rti_d      = is_rti_q;
        ret_pc_d      = ret_pc_q;
        pc_next_d     = pc_next_q;
        flags_sv_d    = flags_sv_q;
        flags_rs_d    = flags_rs_q;
        start         = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = sp_q;
        mem_wdata     = '0;
        flush         = 1'b0;
        pc_load       = 1'b0;
        flags_load    = 1'b0;
        int_ack       = 1'b0;
        stack_err     = 1'b0;

        case (state_q)
            IDLE: begin
                // Interrupt wins; the decode instruction stays held and is served afterwards.
                if (int_pending_q || interrupt) begin
                    start         = 1'b1;
                    int_ack       = 1'b1;
                    int_pending_d = 1'b0;
                    is_int_d      = 1'b1;
                    is_rti_d      = 1'b0;
                    ret_pc_d      = pc_cur;
                    flags_sv_d    = flags_in;
                    pc_next_d     = INT_VECTOR;
                    state_d       = PUSH_HI;
                end else if (op_valid && op_kind != 2'b00) begin
                    start      = 1'b1;
                    is_int_d   = 1'b0;
                    is_rti_d   = (op_kind == 2'b11);
                    ret_pc_d   = pc_cur;
                    flags_sv_d = flags_in;
                    pc_next_d  = PC_W'(target);
                    case (op_kind)
                        2'b01:   state_d = PUSH_HI;
                        2'b10:   state_d = POP_LO;
                        default: state_d = POP_FL;
                    endcase
                end
            end
            PUSH_HI, PUSH_LO, PUSH_FL: begin
                mem_we   = 1'b1;
                mem_addr = sp_q;
                case (state_q)
                    PUSH_HI: mem_wdata = W'(ret_pc_q >> W);
                    PUSH_LO: mem_wdata = W'(ret_pc_q);
                    default: mem_wdata = {{(W-4){1'b0}}, flags_sv_q};
                endcase
                if (push_blocked) begin
                    stack_err = 1'b1;
                    flush     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        sp_d = sp_q - 1'b1;
                        case (state_q)
                            PUSH_HI: state_d = PUSH_LO;
                            PUSH_LO: state_d = is_int_q ? PUSH_FL : JUMP;
                            default: state_d = JUMP;
                        endcase
                    end
                end
            end
            POP_FL, POP_LO, POP_HI: begin
                mem_addr = sp_q + 1'b1;
                if (pop_blocked) begin
                    stack_err = 1'b1;
                    flush     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        sp_d = sp_q + 1'b1;
                        case (state_q)
                            POP_FL: begin
                                flags_rs_d = mem_rdata[3:0];
                                state_d    = POP_LO;
                            end
                            POP_LO: begin
                                pc_next_d = (pc_next_q & ~LO_MASK) | PC_W'(mem_rdata);
                                state_d   = POP_HI;
                            end
                            default: begin
                                pc_next_d = (PC_W'(mem_rdata) << W) | (pc_next_q & LO_MASK);
                                state_d   = JUMP;
                            end
                        endcase
                    end
                end
            end
            JUMP: begin
                pc_load    = 1'b1;
                flush      = 1'b1;
                flags_load = is_rti_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pc_enable = (state_q == IDLE) && !start;
        fd_enable = pc_enable;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sp_q          <= STACK_START;
            int_pending_q <= 1'b0;
            is_int_q      <= 1'b0;
            is_rti_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            int_pending_q <= int_pending_d;
            is_int_q      <= is_int_d;
            is_rti_q      <= is_rti_d;
        end
    end

    // Payload registers carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk) begin
        ret_pc_q   <= ret_pc_d;
        pc_next_q  <= pc_next_d;
        flags_sv_q <= flags_sv_d;
        flags_rs_q <= flags_rs_d;
    end

    assign sp        = sp_q;
    assign pc_next   = pc_next_q;
    assign flags_out = flags_rs_q;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl: stack memory model with programmable ack delay, hand-computed expectations.
module tb_stack_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_kind;
    logic [15:0] target;
    logic        interrupt;
    logic [31:0] pc_cur;
    logic [3:0]  flags_in;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, sp;
    logic        pc_enable, fd_enable, flush, pc_load, flags_load, int_ack, stack_err;
    logic [31:0] pc_next;
    logic [3:0]  flags_out;

    logic [15:0] mem [0:65535];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    stack_seq_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind), .target(target),
        .interrupt(interrupt), .pc_cur(pc_cur), .flags_in(flags_in),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp(sp), .pc_enable(pc_enable),
        .fd_enable(fd_enable), .flush(flush), .pc_load(pc_load), .pc_next(pc_next),
        .flags_load(flags_load), .flags_out(flags_out), .int_ack(int_ack), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // ack_delay==0 holds ack high permanently, so stray acks outside a request are exercised too.
    assign mem_ack   = (ack_delay == 0) ? 1'b1 : (mem_req && wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; op_valid = 1'b0; op_kind = 2'b00; target = '0;
        interrupt = 1'b0; pc_cur = '0; flags_in = '0;
        tick(); tick();
        n_cmp++; if (sp !== 16'd2047) begin n_bad++; $display("FAIL reset_sp: got %0d want 2047", sp); end
        n_cmp++; if ({mem_req, pc_load, flush, int_ack, stack_err, flags_load} !== 6'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 000000", {mem_req, pc_load, flush, int_ack, stack_err, flags_load}); end
        n_cmp++; if ({pc_enable, fd_enable} !== 2'b11) begin
            n_bad++; $display("FAIL reset_enables: got %b want 11", {pc_enable, fd_enable}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_call();
        op_valid = 1'b1; op_kind = 2'b01; target = 16'h0040; pc_cur = 32'h0000_1234; #1;
        n_cmp++; if (pc_enable !== 1'b0) begin n_bad++; $display("FAIL call_stall_start: got %b want 0", pc_enable); end
        tick(); op_valid = 1'b0; pc_cur = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'd2047, 16'h0000}) begin
            n_bad++; $display("FAIL call_push_hi: got req/we=%b%b addr=%0d data=%h want 11 2047 0000", mem_req, mem_we, mem_addr, mem_wdata); end
        tick(); #1;
        n_cmp++; if ({mem_addr, mem_wdata} !== {16'd2046, 16'h1234}) begin
            n_bad++; $display("FAIL call_push_lo: got addr=%0d data=%h want 2046 1234", mem_addr, mem_wdata); end
        tick(); #1;
        n_cmp++; if ({pc_load, flush, mem_req} !== 3'b110 || pc_next !== 32'h0000_0040) begin
            n_bad++; $display("FAIL call_jump: got load/flush/req=%b%b%b pc_next=%h want 110 00000040", pc_load, flush, mem_req, pc_next); end
        n_cmp++; if (sp !== 16'd2045) begin n_bad++; $display("FAIL call_sp: got %0d want 2045", sp); end
        tick(); #1;
        n_cmp++; if ({pc_enable, pc_load} !== 2'b10) begin
            n_bad++; $display("FAIL call_done: got en/load=%b%b want 10", pc_enable, pc_load); end
        n_cmp++; if (mem[2047] !== 16'h0000 || mem[2046] !== 16'h1234) begin
            n_bad++; $display("FAIL call_mem: got [2047]=%h [2046]=%h want 0000 1234", mem[2047], mem[2046]); end
    endtask

    task automatic test_ret();
        int flushes;
        flushes = 0;
        op_valid = 1'b1; op_kind = 2'b10; #1;
        flushes += int'(flush);
        tick(); op_valid = 1'b0; #1;
        flushes += int'(flush);
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'd2046}) begin
            n_bad++; $display("FAIL ret_pop_lo: got req/we=%b%b addr=%0d want 10 2046", mem_req, mem_we, mem_addr); end
        tick(); #1;
        flushes += int'(flush);
        n_cmp++; if (mem_addr !== 16'd2047) begin n_bad++; $display("FAIL ret_pop_hi: got addr=%0d want 2047", mem_addr); end
        tick(); #1;
        flushes += int'(flush);
        n_cmp++; if (pc_load !== 1'b1 || pc_next !== 32'h0000_1234) begin
            n_bad++; $display("FAIL ret_jump: got load=%b pc_next=%h want 1 00001234", pc_load, pc_next); end
        n_cmp++; if (sp !== 16'd2047) begin n_bad++; $display("FAIL ret_sp: got %0d want 2047", sp); end
        tick(); #1;
        flushes += int'(flush);
        tick(); #1;
        flushes += int'(flush);
        n_cmp++; if (flushes !== 1) begin n_bad++; $display("FAIL ret_flush_count: got %0d want 1", flushes); end
    endtask

    task automatic test_call_wait();
        int bad_stall, bad_hold;
        logic [15:0] exp_addr, exp_data;
        bad_stall = 0; bad_hold = 0;
        ack_delay = 2;
        op_valid = 1'b1; op_kind = 2'b01; target = 16'h0080; pc_cur = 32'h0001_5678; #1;
        tick(); op_valid = 1'b0; pc_cur = 32'h0; #1;
        for (int c = 1; c <= 6; c++) begin
            exp_addr = (c <= 3) ? 16'd2047 : 16'd2046;
            exp_data = (c <= 3) ? 16'h0001 : 16'h5678;
            if (pc_enable !== 1'b0 || fd_enable !== 1'b0 || pc_load !== 1'b0) bad_stall++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data) bad_hold++;
            tick(); #1;
        end
        n_cmp++; if (bad_stall !== 0) begin n_bad++; $display("FAIL wait_stall: got %0d bad cycles want 0", bad_stall); end
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL wait_hold: got %0d bad cycles want 0", bad_hold); end
        n_cmp++; if (pc_load !== 1'b1 || pc_next !== 32'h0000_0080) begin
            n_bad++; $display("FAIL wait_jump_c7: got load=%b pc_next=%h want 1 00000080", pc_load, pc_next); end
        n_cmp++; if (sp !== 16'd2045 || mem[2047] !== 16'h0001 || mem[2046] !== 16'h5678) begin
            n_bad++; $display("FAIL wait_result: got sp=%0d [2047]=%h [2046]=%h want 2045 0001 5678", sp, mem[2047], mem[2046]); end
        ack_delay = 0;
        tick();
    endtask

    task automatic test_int_rti();
        interrupt = 1'b1; op_valid = 1'b1; op_kind = 2'b10; pc_cur = 32'hABCD_0010; flags_in = 4'hA; #1;
        n_cmp++; if ({int_ack, pc_enable} !== 2'b10) begin
            n_bad++; $display("FAIL int_start: got ack/en=%b%b want 10", int_ack, pc_enable); end
        tick(); interrupt = 1'b0; #1;
        n_cmp++; if ({mem_addr, mem_wdata, int_ack} !== {16'd2045, 16'hABCD, 1'b0}) begin
            n_bad++; $display("FAIL int_push_hi: got addr=%0d data=%h ack=%b want 2045 abcd 0", mem_addr, mem_wdata, int_ack); end
        tick(); #1;
        n_cmp++; if ({mem_addr, mem_wdata} !== {16'd2044, 16'h0010}) begin
            n_bad++; $display("FAIL int_push_lo: got addr=%0d data=%h want 2044 0010", mem_addr, mem_wdata); end
        tick(); #1;
        n_cmp++; if ({mem_addr, mem_wdata} !== {16'd2043, 16'h000A}) begin
            n_bad++; $display("FAIL int_push_fl: got addr=%0d data=%h want 2043 000a", mem_addr, mem_wdata); end
        tick(); #1;
        n_cmp++; if ({pc_load, flags_load} !== 2'b10 || pc_next !== 32'h0) begin
            n_bad++; $display("FAIL int_jump: got load/fl=%b%b pc_next=%h want 10 00000000", pc_load, flags_load, pc_next); end
        tick(); #1;
        n_cmp++; if ({pc_enable, mem_req} !== 2'b00) begin
            n_bad++; $display("FAIL held_ret_start: got en/req=%b%b want 00", pc_enable, mem_req); end
        tick(); op_valid = 1'b0; #1;
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'd2043}) begin
            n_bad++; $display("FAIL held_ret_pop: got req/we=%b%b addr=%0d want 10 2043", mem_req, mem_we, mem_addr); end
        tick(); tick(); #1;
        n_cmp++; if (pc_load !== 1'b1 || pc_next !== 32'h0010_000A || sp !== 16'd2044) begin
            n_bad++; $display("FAIL held_ret_jump: got load=%b pc_next=%h sp=%0d want 1 0010000a 2044", pc_load, pc_next, sp); end
        tick();
        interrupt = 1'b1; pc_cur = 32'h0000_2222; flags_in = 4'hA; #1;
        tick(); interrupt = 1'b0; flags_in = 4'h5; pc_cur = 32'h0;
        tick(); tick(); tick(); #1;
        n_cmp++; if (pc_load !== 1'b1 || sp !== 16'd2041) begin
            n_bad++; $display("FAIL int2_jump: got load=%b sp=%0d want 1 2041", pc_load, sp); end
        n_cmp++; if ({mem[2044], mem[2043], mem[2042]} !== {16'h0000, 16'h2222, 16'h000A}) begin
            n_bad++; $display("FAIL int2_mem: got %h %h %h want 0000 2222 000a", mem[2044], mem[2043], mem[2042]); end
        tick();
        op_valid = 1'b1; op_kind = 2'b11; #1;
        tick(); op_valid = 1'b0; #1;
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'd2042}) begin
            n_bad++; $display("FAIL rti_pop_fl: got req/we=%b%b addr=%0d want 10 2042", mem_req, mem_we, mem_addr); end
        tick(); interrupt = 1'b1; #1;
        tick(); interrupt = 1'b0; #1;
        tick(); #1;
        n_cmp++; if ({pc_load, flags_load, int_ack} !== 3'b110 || pc_next !== 32'h0000_2222 || flags_out !== 4'hA) begin
            n_bad++; $display("FAIL rti_jump: got load/fl/ack=%b%b%b pc_next=%h flags=%h want 110 00002222 a", pc_load, flags_load, int_ack, pc_next, flags_out); end
        n_cmp++; if (sp !== 16'd2044) begin n_bad++; $display("FAIL rti_sp: got %0d want 2044", sp); end
        tick(); #1;
        n_cmp++; if (int_ack !== 1'b1) begin n_bad++; $display("FAIL pending_int_ack: got %b want 1", int_ack); end
        tick(); tick(); tick(); tick(); #1;
        n_cmp++; if (pc_load !== 1'b1 || pc_next !== 32'h0 || sp !== 16'd2041) begin
            n_bad++; $display("FAIL pending_int_jump: got load=%b pc_next=%h sp=%0d want 1 00000000 2041", pc_load, pc_next, sp); end
        tick();
    endtask

    task automatic test_bounds();
        rst = 1'b0; #1; rst = 1'b1;
        tick();
        op_valid = 1'b1; op_kind = 2'b10; #1;
        tick(); op_valid = 1'b0; #1;
`ifdef STACK_BOUNDS_CHECK_EN
        n_cmp++; if ({mem_req, stack_err, flush} !== 3'b011) begin
            n_bad++; $display("FAIL bounds_err: got req/err/flush=%b%b%b want 011", mem_req, stack_err, flush); end
        tick(); #1;
        n_cmp++; if ({pc_enable, stack_err} !== 2'b10 || sp !== 16'd2047) begin
            n_bad++; $display("FAIL bounds_after: got en/err=%b%b sp=%0d want 10 2047", pc_enable, stack_err, sp); end
`else
        n_cmp++; if ({mem_req, stack_err, mem_addr} !== {2'b10, 16'd2048}) begin
            n_bad++; $display("FAIL wrap_pop: got req/err=%b%b addr=%0d want 10 2048", mem_req, stack_err, mem_addr); end
        tick(); tick(); #1;
        n_cmp++; if ({pc_load, stack_err} !== 2'b10 || sp !== 16'd2049) begin
            n_bad++; $display("FAIL wrap_jump: got load/err=%b%b sp=%0d want 10 2049", pc_load, stack_err, sp); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_kind = 2'b01; target = 16'h0100; pc_cur = 32'h0000_7777; #1;
        tick(); op_valid = 1'b0;
        tick(); #1;
        n_cmp++; if ({mem_req, mem_wdata} !== {1'b1, 16'h7777}) begin
            n_bad++; $display("FAIL mid_push_lo: got req=%b data=%h want 1 7777", mem_req, mem_wdata); end
        rst = 1'b0; #1;
        n_cmp++; if ({mem_req, pc_enable, pc_load} !== 3'b010 || sp !== 16'd2047) begin
            n_bad++; $display("FAIL mid_reset: got req/en/load=%b%b%b sp=%0d want 010 2047", mem_req, pc_enable, pc_load, sp); end
        tick(); rst = 1'b1;
        tick(); #1;
        n_cmp++; if ({mem_req, pc_enable, pc_load} !== 3'b010) begin
            n_bad++; $display("FAIL mid_after: got req/en/load=%b%b%b want 010", mem_req, pc_enable, pc_load); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        test_reset();
        test_call();
        test_ret();
        test_call_wait();
        test_int_rti();
        test_bounds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
